serial_adder: RTL and testbench

Bit-serial adder for two WIDTH-bit operands plus carry-in. It processes one bit per clock, LSB first, through a single full-adder cell and a registered carry. It uses a start/ready/done handshake, so it can be fed by a register file or controller that would otherwise need a WIDTH-bit ripple adder. The intended use is area-constrained datapaths, trading latency for one full-adder cell.

---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry process WIDTH-bit
// operands LSB first, with a start/ready/done handshake around the operation.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:1] r_sr;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_done;

   logic             w_s;
   logic             w_cNext;
   logic             w_last;
   logic [WIDTH-1:0] w_srNext;

   assign w_s      = r_sa[0] ^ r_sb[0] ^ r_c;
   assign w_cNext  = (r_sa[0] & r_sb[0]) | (r_sb[0] & r_c) | (r_c & r_sa[0]);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   // The bit computed this cycle completes the word, so sum can load the shifted value.
   assign w_srNext = {w_s, r_sr};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      ready       = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_sr   <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sa  <= a;
                  r_sb  <= b;
                  r_c   <= cin;
                  r_cnt <= '0;
               end
            end
            SHIFT: begin
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_sr  <= w_srNext[WIDTH-1:1];
               r_c   <= w_cNext;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum  <= w_srNext;
                  r_cout <= w_cNext;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder at WIDTH=8 and WIDTH=16; results are compared with
// plain a+b+cin arithmetic.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst8, start8, cin8, ready8, busy8, done8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        rst16, start16, cin16, ready16, busy16, done16, cout16;
   logic [15:0] a16, b16, sum16;

   int compCount = 0;
   int failCount = 0;
   logic [8:0] lastRes8;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_adder #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request for a cycle, then scramble inputs to prove they were captured.
   task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
   endtask

   task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic cin, input string tag);
      logic [8:0] expv;
      int busyCnt;
      int cyc;
      expv = 9'(a) + 9'(b) + 9'(cin);
      busyCnt = 0;
      cyc = 0;
      applyStimulus8(a, b, cin);
      while (!done8 && cyc < 20) begin
         if (busy8) busyCnt++;
         checkOutput({tag, "_hold"}, 64'({cout8, sum8}), 64'(lastRes8));
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, "_done"}, 64'(done8), 64'd1);
      checkOutput({tag, "_latency"}, 64'(cyc), 64'd8);
      checkOutput({tag, "_busycnt"}, 64'(busyCnt), 64'd8);
      checkOutput({tag, "_ready"}, 64'(ready8), 64'd1);
      checkOutput({tag, "_result"}, 64'({cout8, sum8}), 64'(expv));
      lastRes8 = expv;
      @(negedge clk);
      checkOutput({tag, "_donelow"}, 64'(done8), 64'd0);
   endtask

   task automatic runOp16(input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic [16:0] expv;
      int cyc;
      expv = 17'(a) + 17'(b) + 17'(cin);
      cyc = 0;
      a16 = a; b16 = b; cin16 = cin; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      while (!done16 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("rand16_done", 64'(done16), 64'd1);
      checkOutput("rand16_result", 64'({cout16, sum16}), 64'(expv));
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] opA [4];
      logic [7:0] opB [4];
      logic [8:0] expQ [4];
      int doneCount;
      int idx;
      int lastDone;

      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      rst16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      lastRes8 = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 64'(ready8), 64'd1);
      checkOutput("rst_busy", 64'(busy8), 64'd0);
      checkOutput("rst_done", 64'(done8), 64'd0);
      checkOutput("rst_sum", 64'(sum8), 64'd0);
      checkOutput("rst_cout", 64'(cout8), 64'd0);
      rst8 = 1'b0; rst16 = 1'b0;
      @(negedge clk);

      runOp8(8'h5A, 8'h3C, 1'b0, "op5A3C");
      runOp8(8'hFF, 8'h01, 1'b0, "opFF01");
      runOp8(8'hFF, 8'hFF, 1'b1, "opFFFF1");
      runOp8(8'h00, 8'h00, 1'b1, "op00001");

      // Start pulses during the busy phase must be ignored.
      applyStimulus8(8'h12, 8'h34, 1'b0);
      doneCount = 0;
      for (int i = 1; i <= 20; i++) begin
         if (done8) begin
            doneCount++;
            checkOutput("ign_result", 64'({cout8, sum8}), 64'h046);
            checkOutput("ign_when", 64'(i), 64'd9);
         end
         if (i == 3 || i == 5) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      start8 = 1'b0;
      checkOutput("ign_donecount", 64'(doneCount), 64'd1);
      lastRes8 = 9'h046;

      // Back-to-back with start held high.
      opA[0] = 8'h11; opB[0] = 8'h22;
      opA[1] = 8'hF0; opB[1] = 8'h20;
      opA[2] = 8'h80; opB[2] = 8'h80;
      opA[3] = 8'h7F; opB[3] = 8'h01;
      for (int i = 0; i < 4; i++) expQ[i] = 9'(opA[i]) + 9'(opB[i]);
      idx = 0;
      lastDone = -1;
      a8 = opA[0]; b8 = opB[0]; cin8 = 1'b0; start8 = 1'b1;
      for (int cyc = 0; cyc < 60 && idx < 4; cyc++) begin
         @(negedge clk);
         if (done8) begin
            checkOutput("b2b_result", 64'({cout8, sum8}), 64'(expQ[idx]));
            if (lastDone >= 0) checkOutput("b2b_spacing", 64'(cyc - lastDone), 64'd9);
            lastDone = cyc;
            lastRes8 = expQ[idx];
            idx++;
            if (idx < 4) begin
               a8 = opA[idx]; b8 = opB[idx];
            end else begin
               start8 = 1'b0;
            end
         end else if (busy8) begin
            checkOutput("b2b_hold", 64'({cout8, sum8}), 64'(lastRes8));
         end
      end
      start8 = 1'b0;
      checkOutput("b2b_count", 64'(idx), 64'd4);
      @(negedge clk);

      // Reset in the middle of an operation aborts it without a done pulse.
      applyStimulus8(8'hAB, 8'hCD, 1'b1);
      repeat (3) @(negedge clk);
      rst8 = 1'b1;
      @(negedge clk);
      rst8 = 1'b0;
      checkOutput("abort_ready", 64'(ready8), 64'd1);
      checkOutput("abort_busy", 64'(busy8), 64'd0);
      checkOutput("abort_done", 64'(done8), 64'd0);
      checkOutput("abort_sum", 64'(sum8), 64'd0);
      checkOutput("abort_cout", 64'(cout8), 64'd0);
      lastRes8 = '0;
      doneCount = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) doneCount++;
      end
      checkOutput("abort_nodone", 64'(doneCount), 64'd0);
      runOp8(8'h21, 8'h43, 1'b1, "postabort");

      // Reset and start together: reset wins.
      rst8 = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
      @(negedge clk);
      rst8 = 1'b0; start8 = 1'b0;
      lastRes8 = '0;
      checkOutput("rststart_ready", 64'(ready8), 64'd1);
      @(negedge clk);
      checkOutput("rststart_busy", 64'(busy8), 64'd0);

      for (int n = 0; n < 600; n++) begin
         runOp8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");
      end
      for (int n = 0; n < 600; n++) begin
         runOp16(16'($urandom), 16'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
      $finish;
   end

endmodule
